// File: rtl/scsp_slot_sequencer_pkg.sv
// Shared types and sizing for the SCSP slot sequencer.
// Holds slot/phase geometry, the per-stage pipeline payload and the
// requester encoding used by the sound-RAM arbiter.
package scsp_slot_sequencer_pkg;

    localparam int unsigned SLOT_CNT     = 32;
    localparam int unsigned CYC_PER_SLOT = 16;
    localparam int unsigned EXT_PHASE    = 8;
    localparam int unsigned PIPE_STAGES  = 7;

    localparam int unsigned SLOT_W  = $clog2(SLOT_CNT);
    localparam int unsigned PHASE_W = $clog2(CYC_PER_SLOT);

    // One pipeline stage: which slot it carries and its key events.
    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic              kon;
        logic              koff;
    } oppipe_t;

    typedef oppipe_t [1:PIPE_STAGES] oppipe_arr_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_t;

    localparam oppipe_t OP_PIPE_RESET = oppipe_t'(0);

endpackage

// File: rtl/scsp_ram_arb.sv
// Two-way round-robin arbiter for the shared external sound-RAM window.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ce                clock enable; grants and pointer updates only when high
//   slot_phase        cycle within the current slot
//   cpu_req, dma_req  level requests, held until acknowledged
//   cpu_ack, dma_ack  one-cycle grants in the window cycle (combinational)
//   ext_sel           window cycle indicator (combinational)
module scsp_ram_arb
    import scsp_slot_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic [PHASE_W-1:0] slot_phase,
    input  logic               cpu_req,
    input  logic               dma_req,
    output logic               cpu_ack,
    output logic               dma_ack,
    output logic               ext_sel
);

    req_t rr_ptr;
    req_t rr_ptr_nxt;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= REQ_CPU;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Grant decode; the pointer only moves when both requesters contend.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        cpu_ack    = 1'b0;
        dma_ack    = 1'b0;
        ext_sel    = (slot_phase == PHASE_W'(EXT_PHASE));
        if (rst_n && ce && ext_sel) begin
            if (cpu_req && dma_req) begin
                if (rr_ptr == REQ_CPU) begin
                    cpu_ack    = 1'b1;
                    rr_ptr_nxt = REQ_DMA;
                end else begin
                    dma_ack    = 1'b1;
                    rr_ptr_nxt = REQ_CPU;
                end
            end else if (cpu_req) begin
                cpu_ack = 1'b1;
            end else if (dma_req) begin
                dma_ack = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scsp_slot_sequencer.sv
// SCSP master slot sequencer: slot/phase counters, KYONEX snapshot into
// exactly-once KON/KOFF events, the OP1..OP7 slot pipeline and the
// sound-RAM time windows.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ce                clock enable; all state advances only when high
//   kyonex            one-cycle pulse, CPU wrote KX=1
//   kb                current KB bit of every slot
//   cpu_req, dma_req  sound-RAM requests (level)
//   cpu_ack, dma_ack  one-CE-cycle grants
//   slot_num          slot currently in OP1
//   slot_phase        cycle within current slot
//   sample_start      first cycle of slot 0
//   wave_sel          RAM owned by the slot datapath (phases 0,1)
//   ext_sel           RAM owned by CPU/DMA
//   op_pipe           per-stage {slot, kon, koff}, stage 1 = OP1
module scsp_slot_sequencer
    import scsp_slot_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                kyonex,
    input  logic [SLOT_CNT-1:0] kb,
    input  logic                cpu_req,
    input  logic                dma_req,
    output logic                cpu_ack,
    output logic                dma_ack,
    output logic [SLOT_W-1:0]   slot_num,
    output logic [PHASE_W-1:0]  slot_phase,
    output logic                sample_start,
    output logic                wave_sel,
    output logic                ext_sel,
    output oppipe_arr_t         op_pipe
);

    logic [SLOT_CNT-1:0] kb_prev,   kb_prev_nxt;
    logic [SLOT_CNT-1:0] kon_pend,  kon_pend_nxt;
    logic [SLOT_CNT-1:0] koff_pend, koff_pend_nxt;
    logic                kyon_pend, kyon_pend_nxt;
    logic [SLOT_W-1:0]   slot_num_nxt;
    logic [PHASE_W-1:0]  slot_phase_nxt;
    oppipe_arr_t         op_pipe_nxt;

    logic                last_phase;
    logic                snap;
    logic [SLOT_W-1:0]   slot_inc;
    logic [SLOT_CNT-1:0] kon_eff;
    logic [SLOT_CNT-1:0] koff_eff;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_num   <= '0;
            slot_phase <= '0;
            op_pipe    <= {PIPE_STAGES{OP_PIPE_RESET}};
            kb_prev    <= '0;
            kon_pend   <= '0;
            koff_pend  <= '0;
            kyon_pend  <= 1'b0;
        end else begin
            slot_num   <= slot_num_nxt;
            slot_phase <= slot_phase_nxt;
            op_pipe    <= op_pipe_nxt;
            kb_prev    <= kb_prev_nxt;
            kon_pend   <= kon_pend_nxt;
            koff_pend  <= koff_pend_nxt;
            kyon_pend  <= kyon_pend_nxt;
        end
    end

    // Next-state: counters, event snapshot and pipeline shift.
    always_comb begin
        slot_num_nxt   = slot_num;
        slot_phase_nxt = slot_phase;
        op_pipe_nxt    = op_pipe;
        kb_prev_nxt    = kb_prev;
        kon_pend_nxt   = kon_pend;
        koff_pend_nxt  = koff_pend;
        kyon_pend_nxt  = kyon_pend;

        last_phase = (slot_phase == PHASE_W'(CYC_PER_SLOT - 1));
        slot_inc   = slot_num + SLOT_W'(1);
        snap       = last_phase && (slot_num == SLOT_W'(SLOT_CNT - 1)) &&
                     (kyon_pend || kyonex);
        kon_eff    = kon_pend;
        koff_eff   = koff_pend;

        if (ce) begin
            slot_phase_nxt = slot_phase + PHASE_W'(1);

            if (kyonex) begin
                kyon_pend_nxt = 1'b1;
            end

            // Snapshot edge also loads slot 0, so fresh edges bypass into OP1.
            if (snap) begin
                kon_eff       = kon_pend  | (kb & ~kb_prev);
                koff_eff      = koff_pend | (~kb & kb_prev);
                kb_prev_nxt   = kb;
                kyon_pend_nxt = 1'b0;
            end

            if (last_phase) begin
                slot_num_nxt = slot_inc;
                for (int unsigned k = PIPE_STAGES; k >= 2; k--) begin
                    op_pipe_nxt[k] = op_pipe[k-1];
                end
                op_pipe_nxt[1] = '{slot: slot_inc,
                                   kon:  kon_eff[slot_inc],
                                   koff: koff_eff[slot_inc]};
                // Each event is handed to the pipeline exactly once.
                kon_pend_nxt  = kon_eff  & ~(SLOT_CNT'(1) << slot_inc);
                koff_pend_nxt = koff_eff & ~(SLOT_CNT'(1) << slot_inc);
            end
        end
    end

    assign sample_start = (slot_num == '0) && (slot_phase == '0);
    assign wave_sel     = (slot_phase < PHASE_W'(2));

    scsp_ram_arb u_ram_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .slot_phase (slot_phase),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .cpu_ack    (cpu_ack),
        .dma_ack    (dma_ack),
        .ext_sel    (ext_sel)
    );

endmodule

// File: tb/tb_scsp_slot_sequencer.sv
// Directed testbench for scsp_slot_sequencer.
module tb_scsp_slot_sequencer;
    import scsp_slot_sequencer_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ce;
    logic                kyonex;
    logic [SLOT_CNT-1:0] kb;
    logic                cpu_req;
    logic                dma_req;
    logic                cpu_ack;
    logic                dma_ack;
    logic [SLOT_W-1:0]   slot_num;
    logic [PHASE_W-1:0]  slot_phase;
    logic                sample_start;
    logic                wave_sel;
    logic                ext_sel;
    oppipe_arr_t         op_pipe;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;  // CE cycles since reset, modulo one sample

    always #5 clk = ~clk;

    scsp_slot_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .kyonex       (kyonex),
        .kb           (kb),
        .cpu_req      (cpu_req),
        .dma_req      (dma_req),
        .cpu_ack      (cpu_ack),
        .dma_ack      (dma_ack),
        .slot_num     (slot_num),
        .slot_phase   (slot_phase),
        .sample_start (sample_start),
        .wave_sel     (wave_sel),
        .ext_sel      (ext_sel),
        .op_pipe      (op_pipe)
    );

    function automatic oppipe_t mk(int s, logic kon, logic koff);
        return '{slot: SLOT_W'(s), kon: kon, koff: koff};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_op(string tag, oppipe_t obs, oppipe_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed={slot=%0d kon=%0b koff=%0b} expected={slot=%0d kon=%0b koff=%0b}",
                   tag, obs.slot, obs.kon, obs.koff, exp.slot, exp.kon, exp.koff);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce && rst_n) cyc = (cyc + 1) % (SLOT_CNT * CYC_PER_SLOT);
    endtask

    // Advance (CE held high) to the given slot/phase; bounded by one sample.
    task automatic goto(int s, int p);
        int t;
        int n;
        t = s * CYC_PER_SLOT + p;
        n = (t - cyc + SLOT_CNT * CYC_PER_SLOT) % (SLOT_CNT * CYC_PER_SLOT);
        repeat (n) tick();
    endtask

    task automatic pulse_kyonex();
        kyonex = 1'b1;
        tick();
        kyonex = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; kyonex = 1'b0; kb = '0;
        cpu_req = 1'b0; dma_req = 1'b0;

        // Reset with CE high
        repeat (3) tick();
        cyc = 0;
        chk("rst_slot", 32'(slot_num), 32'd0);
        chk("rst_phase", 32'(slot_phase), 32'd0);
        chk("rst_pipe", 32'(op_pipe[1]) | 32'(op_pipe[7]), 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("rst_sstart", 32'(sample_start), 32'd1);
        chk("rst_sel", {30'd0, wave_sel, ext_sel}, 32'b10);
        rst_n = 1'b1;

        // One full sample wraps back to slot 0
        tick();
        chk("sstart_low", 32'(sample_start), 32'd0);
        repeat (SLOT_CNT * CYC_PER_SLOT - 1) tick();
        chk("wrap_sstart", 32'(sample_start), 32'd1);
        chk("wrap_slot", 32'(slot_num), 32'd0);
        chk_op("wrap_op2", op_pipe[2], mk(31, 0, 0));
        goto(10, 3);
        chk("cnt_slot", 32'(slot_num), 32'd10);
        chk("cnt_phase", 32'(slot_phase), 32'd3);

        // KB=5 + KYONEX at slot 10: KON at slots 0 and 2 next sample
        kb = 32'h0000_0005;
        pulse_kyonex();
        goto(31, 15);
        chk_op("kon_none_op1", op_pipe[1], mk(31, 0, 0));
        chk_op("kon_none_op7", op_pipe[7], mk(25, 0, 0));
        tick();
        chk_op("kon_s0", op_pipe[1], mk(0, 1, 0));
        goto(1, 0);
        chk_op("kon_s1", op_pipe[1], mk(1, 0, 0));
        chk_op("kon_s0_op2", op_pipe[2], mk(0, 1, 0));
        goto(2, 0);
        chk_op("kon_s2", op_pipe[1], mk(2, 1, 0));
        goto(6, 0);
        chk_op("kon_s0_op7", op_pipe[7], mk(0, 1, 0));
        goto(8, 0);
        chk_op("kon_s2_op7", op_pipe[7], mk(2, 1, 0));
        goto(0, 0);
        chk_op("kon_once_s0", op_pipe[1], mk(0, 0, 0));
        goto(2, 0);
        chk_op("kon_once_s2", op_pipe[1], mk(2, 0, 0));

        // KB=0 + KYONEX: KOFF at slots 0 and 2
        kb = '0;
        goto(5, 0);
        pulse_kyonex();
        goto(0, 0);
        chk_op("koff_s0", op_pipe[1], mk(0, 0, 1));
        goto(1, 0);
        chk_op("koff_s1", op_pipe[1], mk(1, 0, 0));
        goto(2, 0);
        chk_op("koff_s2", op_pipe[1], mk(2, 0, 1));

        // KYONEX with KB unchanged: nothing
        goto(10, 0);
        pulse_kyonex();
        goto(0, 0);
        chk_op("same_s0", op_pipe[1], mk(0, 0, 0));
        goto(2, 0);
        chk_op("same_s2", op_pipe[1], mk(2, 0, 0));

        // KYONEX exactly on the snapshot cycle
        kb = 32'h0000_0001;
        goto(31, 15);
        pulse_kyonex();
        chk_op("late_kx_s0", op_pipe[1], mk(0, 1, 0));
        goto(1, 0);
        chk_op("late_kx_op2", op_pipe[2], mk(0, 1, 0));

        // Arbiter: both requesting alternates, CPU first
        goto(2, 1);
        chk("wave_p1", {30'd0, wave_sel, ext_sel}, 32'b10);
        tick();
        chk("wave_p2", {30'd0, wave_sel, ext_sel}, 32'b00);
        cpu_req = 1'b1; dma_req = 1'b1;
        goto(2, 8);
        chk("rr_1", {29'd0, ext_sel, cpu_ack, dma_ack}, 32'b110);
        tick();
        chk("rr_1_after", {29'd0, ext_sel, cpu_ack, dma_ack}, 32'b000);
        goto(3, 8);
        chk("rr_2", {30'd0, cpu_ack, dma_ack}, 32'b01);
        goto(4, 8);
        chk("rr_3", {30'd0, cpu_ack, dma_ack}, 32'b10);
        dma_req = 1'b0;
        goto(5, 8);
        chk("cpu_only_1", {30'd0, cpu_ack, dma_ack}, 32'b10);
        goto(6, 8);
        chk("cpu_only_2", {30'd0, cpu_ack, dma_ack}, 32'b10);

        // CE toggling: half-rate advance, ACK only with CE
        goto(7, 6);
        ce = 1'b0; tick();
        chk("ce_hold", 32'(slot_phase), 32'd6);
        ce = 1'b1; tick();
        ce = 1'b0; tick();
        ce = 1'b1; tick();
        chk("ce_phase8", 32'(slot_phase), 32'd8);
        ce = 1'b0; #1;
        chk("ce0_noack", {30'd0, cpu_ack, dma_ack}, 32'b00);
        ce = 1'b1; #1;
        chk("ce1_ack", {30'd0, cpu_ack, dma_ack}, 32'b10);
        tick();
        for (int i = 0; i < 16; i++) begin
            ce = (i % 2 == 1);
            tick();
        end
        chk("ce_half_slot", 32'(slot_num), 32'd8);
        chk("ce_half_phase", 32'(slot_phase), 32'd1);
        ce = 1'b1;
        cpu_req = 1'b0;

        // Mid-sample reset discards a pending KON for slot 25
        kb = 32'h0200_0001;
        goto(10, 0);
        pulse_kyonex();
        goto(0, 0);
        goto(20, 0);
        rst_n = 1'b0;
        tick();
        cyc = 0;
        chk("mid_rst_cnt", {23'd0, slot_num, slot_phase}, 32'd0);
        chk_op("mid_rst_op1", op_pipe[1], OP_PIPE_RESET);
        rst_n = 1'b1;
        goto(25, 0);
        chk_op("mid_rst_drop", op_pipe[1], mk(25, 0, 0));
        goto(0, 0);
        chk_op("no_kx_no_evt", op_pipe[1], mk(0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
